// File: rtl/amiga_rst_seq.sv
// amiga_rst_seq: PLL lock supervisor and staged reset sequencer.
// Filters the raw PLL lock flag and releases the SDRAM reset first, then the
// CPU/chipset reset. Also generates a 28 MHz / 7 MHz clock-enable pair and
// counts lock-loss events for the debug register.
module amiga_rst_seq #(
    parameter int STABLE_CYCLES     = 1024,
    parameter int SDRAM_INIT_CYCLES = 22800,
    parameter int CPU_DELAY_CYCLES  = 256,
    parameter int LOSS_W            = 8
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              pll_locked,
    input  logic              sw_reset,
    output logic              sdram_rst_n,
    output logic              sys_rst_n,
    output logic              ena28,
    output logic              ena7,
    output logic [3:0]        phase,
    output logic [2:0]        seq_state,
    output logic [LOSS_W-1:0] lock_loss_cnt
);

    // The shared cycle counter must reach the largest terminal count.
    localparam int MAX_AB  = (STABLE_CYCLES > SDRAM_INIT_CYCLES) ? STABLE_CYCLES : SDRAM_INIT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > CPU_DELAY_CYCLES) ? MAX_AB : CPU_DELAY_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SDRAM_LAST  = CNT_W'(SDRAM_INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABILIZE  = 3'd1,
        SDRAM_INIT = 3'd2,
        CPU_HOLD   = 3'd3,
        RUN        = 3'd4,
        LOST       = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               sync1_q, sync2_q;
    logic               sdram_q, sdram_d;
    logic               sys_q, sys_d;
    logic               ena28_q, ena28_d;
    logic               ena7_q, ena7_d;
    logic [3:0]         phase_q, phase_d;
    logic [LOSS_W-1:0]  loss_q;

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic; lock loss outranks soft reset and counter expiry.
    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: begin
                if (sync2_q) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!sync2_q)                 state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = SDRAM_INIT;
            end
            SDRAM_INIT: begin
                if (!sync2_q)                state_d = LOST;
                else if (cnt_q == SDRAM_LAST) state_d = CPU_HOLD;
            end
            CPU_HOLD: begin
                if (!sync2_q)              state_d = LOST;
                else if (cnt_q == CPU_LAST) state_d = RUN;
            end
            RUN: begin
                if (!sync2_q)     state_d = LOST;
                else if (sw_reset) state_d = CPU_HOLD;
            end
            LOST:    state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Reset and clock-enable outputs decoded from the next state.
    always_comb begin
        sdram_d = (state_d == SDRAM_INIT) || (state_d == CPU_HOLD) || (state_d == RUN);
        sys_d   = (state_d == RUN);
        // Phase starts at 0 on the release edge and counts only while SDRAM is out of reset.
        phase_d = (sdram_d && sdram_q) ? phase_q + 4'd1 : 4'd0;
        ena28_d = sdram_d && (phase_d[1:0] == 2'b11);
        ena7_d  = sdram_d && (phase_d == 4'hF);
    end

    // Sequencer state, shared counter, registered resets and lock-loss counter.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            sdram_q <= 1'b0;
            sys_q   <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            sdram_q <= sdram_d;
            sys_q   <= sys_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if ((state_q == STABILIZE) || (state_q == SDRAM_INIT) || (state_q == CPU_HOLD)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if ((state_d == LOST) && (state_q != LOST) && (loss_q != '1)) begin
                loss_q <= loss_q + 1'b1;
            end
        end
    end

    // Phase counter and registered clock enables.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            phase_q <= 4'd0;
            ena28_q <= 1'b0;
            ena7_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ena28_q <= ena28_d;
            ena7_q  <= ena7_d;
        end
    end

    assign sdram_rst_n   = sdram_q;
    assign sys_rst_n     = sys_q;
    assign ena28         = ena28_q;
    assign ena7          = ena7_q;
    assign phase         = phase_q;
    assign seq_state     = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_amiga_rst_seq.sv
// Self-checking bench for amiga_rst_seq with small timing parameters.
// The reference model tracks how long lock has been held and how long ago the
// last soft reset was taken, and derives every output from those ages.
module tb_amiga_rst_seq;

    localparam int S   = 4;
    localparam int I   = 8;
    localparam int C   = 4;
    localparam int LW  = 2;
    localparam int SAT = (1 << LW) - 1;
    localparam int BIG = 1000000;

    logic          clk = 1'b0;
    logic          areset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          sw_reset = 1'b0;
    logic          sdram_rst_n, sys_rst_n, ena28, ena7;
    logic [3:0]    phase;
    logic [2:0]    seq_state;
    logic [LW-1:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    amiga_rst_seq #(
        .STABLE_CYCLES(S), .SDRAM_INIT_CYCLES(I), .CPU_DELAY_CYCLES(C), .LOSS_W(LW)
    ) dut (
        .clk(clk), .areset_n(areset_n), .pll_locked(pll_locked), .sw_reset(sw_reset),
        .sdram_rst_n(sdram_rst_n), .sys_rst_n(sys_rst_n), .ena28(ena28), .ena7(ena7),
        .phase(phase), .seq_state(seq_state), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_age: edges since lock-stable counting began (-1 = waiting for lock).
    // m_sw_age: edges since the last accepted soft reset.
    bit m_s1 = 0, m_s2 = 0, m_lost = 0;
    int m_age = -1, m_sw_age = BIG, m_cnt = 0;

    function automatic bit e_sdram();
        return !m_lost && (m_age >= S);
    endfunction
    function automatic bit e_sys();
        return e_sdram() && (m_age >= S + I + C) && (m_sw_age >= C);
    endfunction
    function automatic int e_phase();
        return e_sdram() ? (m_age - S) % 16 : 0;
    endfunction
    function automatic int e_state();
        if (m_lost)         return 5;
        if (m_age < 0)      return 0;
        if (m_age < S)      return 1;
        if (m_age < S + I)  return 2;
        if (!e_sys())       return 3;
        return 4;
    endfunction

    always @(posedge clk or negedge areset_n) begin
        bit ls, run_before;
        if (!areset_n) begin
            m_s1 = 0; m_s2 = 0; m_lost = 0; m_age = -1; m_sw_age = BIG; m_cnt = 0;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            run_before = e_sys();
            if (m_lost) begin
                m_lost = 0;
                m_age  = -1;
            end else if (m_age < 0) begin
                if (ls) m_age = 0;
            end else if (!ls) begin
                if (m_age >= S) begin
                    m_lost = 1;
                    if (m_cnt < SAT) m_cnt++;
                end
                m_age    = -1;
                m_sw_age = BIG;
            end else begin
                m_age++;
                if (run_before && sw_reset) m_sw_age = 0;
                else if (m_sw_age < BIG)    m_sw_age++;
            end
        end
    end

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        if (areset_n) begin
            check("state", seq_state, e_state());
            check("sdram_rst_n", sdram_rst_n, e_sdram());
            check("sys_rst_n", sys_rst_n, e_sys());
            check("phase", phase, e_phase());
            check("ena28", ena28, e_sdram() && (e_phase() % 4 == 3));
            check("ena7", ena7, e_sdram() && (e_phase() == 15));
            check("loss_cnt", lock_loss_cnt, m_cnt);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_sdram"}, sdram_rst_n, 0);
        check({tag, "_sys"}, sys_rst_n, 0);
        check({tag, "_ena28"}, ena28, 0);
        check({tag, "_ena7"}, ena7, 0);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_state"}, seq_state, 0);
        check({tag, "_loss"}, lock_loss_cnt, 0);
    endtask

    // Reset with lock held high, then check release edges E6 / E18.
    task automatic powerup(input int sw_at);
        areset_n = 1'b0; pll_locked = 1'b1; sw_reset = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("in_reset");
        areset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sw_reset = (k == sw_at);
            @(negedge clk);
            check("pu_sdram_edge", sdram_rst_n, k >= S + 2);
            check("pu_sys_edge", sys_rst_n, k >= S + 2 + I + C);
        end
        sw_reset = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (sys_rst_n !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("run_timeout", 0, 1);
    endtask

    // Drop lock for 3 sampled edges; LOST is entered two edges after the first.
    task automatic lose_lock(input int exp_cnt);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("lost_state", seq_state, 5);
        check("lost_sdram", sdram_rst_n, 0);
        check("lost_sys", sys_rst_n, 0);
        check("lost_phase", phase, 0);
        check("lost_ena", {ena28, ena7}, 0);
        check("lost_cnt", lock_loss_cnt, exp_cnt);
        pll_locked = 1'b1;
    endtask

    initial begin
        int c28, c7, lows, sd_lows, drop;

        // Power-up sequence.
        powerup(-1);
        lose_lock(1);

        // Lock glitch during STABILIZE.
        areset_n = 1'b0;
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        repeat (4) @(negedge clk);            // edges E0..E3 done
        check("stab_state", seq_state, 1);
        pll_locked = 1'b0;                    // sampled at E4
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (2) @(negedge clk);            // E6: FSM sees the glitch
        check("glitch_state", seq_state, 0);
        check("glitch_cnt", lock_loss_cnt, 0);
        check("glitch_sdram", sdram_rst_n, 0);

        // Soft reset in RUN: CPU reset low for exactly C cycles.
        wait_run();
        sw_reset = 1'b1;
        @(negedge clk);
        sw_reset = 1'b0;
        lows = 0; sd_lows = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (!sys_rst_n) lows++;
            if (!sdram_rst_n) sd_lows++;
        end
        check("soft_low_cycles", lows, C);
        check("soft_sdram_low", sd_lows, 0);

        // Soft reset during SDRAM_INIT is ignored (sys still rises at E18).
        powerup(S + 4);

        // Enable cadence in RUN.
        c28 = 0; c7 = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (ena28) c28++;
            if (ena7)  c7++;
        end
        check("ena28_count", c28, 8);
        check("ena7_count", c7, 2);

        // Saturating lock-loss counter.
        for (int k = 0; k < 5; k++) begin
            wait_run();
            lose_lock((k + 1 > SAT) ? SAT : k + 1);
        end
        wait_run();
        check("sat_final", lock_loss_cnt, SAT);

        // Randomized lock drops and soft-reset pulses.
        drop = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            sw_reset = ($urandom_range(0, 15) == 0);
            if (drop > 0) begin
                drop--;
                pll_locked = (drop == 0);
            end else if ($urandom_range(0, 59) == 0) begin
                drop = $urandom_range(1, 4);
                pll_locked = 1'b0;
            end
        end
        sw_reset = 1'b0;
        pll_locked = 1'b1;

        // Asynchronous reset mid-RUN, between clock edges.
        wait_run();
        wait_run();
        @(posedge clk);
        #2 areset_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        areset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
